ifid_hazard_stage: RTL and testbench

IFID_HAZARD_STAGE -- requirements
Module: ifid_hazard_stage

---
 rtl/ifid_hazard_stage_pkg.sv | 24 ++
 rtl/ifid_hazard_stage_if.sv | 31 +++
 rtl/ifid_hazard_stage_load_use_detect.sv | 19 +
 rtl/ifid_hazard_stage.sv | 112 +++++++++++
 tb/tb_ifid_hazard_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ifid_hazard_stage_pkg.sv
// Shared pipeline definitions for the IF/ID hazard stage:
// FSM state encoding, per-cycle event codes and the default NOP word.
package ifid_hazard_stage_pkg;

  // Default instruction word placed in IF/ID on flush or reset.
  localparam logic [31:0] PKG_NOP_INSTR = 32'h0000_0000;

  // Hazard-control FSM states.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FREEZE   = 2'd2
  } hz_state_e;

  // The single event that wins arbitration in a given cycle.
  typedef enum logic [2:0] {
    EV_NORMAL   = 3'd0,
    EV_FREEZE   = 3'd1,
    EV_BRANCH   = 3'd2,
    EV_LOAD_USE = 3'd3,
    EV_JUMP     = 3'd4
  } hz_event_e;

endpackage

// File: rtl/ifid_hazard_stage_if.sv
// Bus between the fetch/decode front end and the IF/ID hazard stage.
// master = environment side driving fetch and hazard inputs,
// slave  = the hazard stage itself.
interface ifid_hazard_stage_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instruction_in;
  logic [31:0]      pcplus_in;
  logic             idex_memrd;
  logic [4:0]       idex_rt;
  logic             jump;
  logic             branch_taken;
  logic             mem_busy;
  logic [31:0]      instruction_out;
  logic [31:0]      pcplus_out;
  logic             valid_out;
  logic             pc_write;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output instruction_in, pcplus_in, idex_memrd, idex_rt, jump, branch_taken, mem_busy,
    input  instruction_out, pcplus_out, valid_out, pc_write, idex_bubble, stall_cnt, flush_cnt
  );

  modport slave (
    input  instruction_in, pcplus_in, idex_memrd, idex_rt, jump, branch_taken, mem_busy,
    output instruction_out, pcplus_out, valid_out, pc_write, idex_bubble, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ifid_hazard_stage_load_use_detect.sv
// Combinational load-use detector. Compares the ID/EX load destination
// against both source fields of the instruction in IF/ID; the Rt field is
// compared even for instructions that do not read it (conservative).
module load_use_detect (
  input  logic        i_idex_memrd,
  input  logic [4:0]  i_idex_rt,
  input  logic [31:0] i_ifid_instr,
  input  logic        i_ifid_valid,
  output logic        o_lu
);
  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_idex_rt == i_ifid_instr[25:21]);
  assign w_rt_match = (i_idex_rt == i_ifid_instr[20:16]);

  // $zero is never a real dependency, so rt==0 can never stall.
  assign o_lu = i_idex_memrd && (i_idex_rt != 5'd0) && (w_rs_match || w_rt_match) && i_ifid_valid;
endmodule

// File: rtl/ifid_hazard_stage.sv
// IF/ID pipeline register with hazard control: freeze on memory busy,
// flush on taken branch or jump, one-cycle load-use stall, and saturating
// stall/flush event counters.
module ifid_hazard_stage
  import ifid_hazard_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PCPLUS = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = PKG_NOP_INSTR,
  parameter int          CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  ifid_hazard_stage_if.slave  bus
);
  hz_state_e        r_state;
  hz_state_e        w_next_state;
  hz_event_e        w_event;
  logic             w_lu;
  logic             w_pc_write;
  logic             w_bubble;
  logic [31:0]      r_instr;
  logic [31:0]      r_pcplus;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  load_use_detect u_load_use_detect (
    .i_idex_memrd (bus.idex_memrd),
    .i_idex_rt    (bus.idex_rt),
    .i_ifid_instr (r_instr),
    .i_ifid_valid (r_valid),
    .o_lu         (w_lu)
  );

  // Arbitrate this cycle's event and derive PC/bubble controls and next state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_event      = EV_NORMAL;
    w_next_state = ST_RUN;
    w_pc_write   = 1'b1;
    w_bubble     = 1'b0;

    if (bus.mem_busy)                       w_event = EV_FREEZE;
    else if (bus.branch_taken)              w_event = EV_BRANCH;
    else if (w_lu && (r_state == ST_RUN))   w_event = EV_LOAD_USE;
    else if (bus.jump)                      w_event = EV_JUMP;

    case (w_event)
      EV_FREEZE: begin
        w_pc_write   = 1'b0;
        w_next_state = ST_FREEZE;
      end
      EV_BRANCH:   w_bubble = 1'b1;
      EV_LOAD_USE: begin
        w_pc_write   = 1'b0;
        w_bubble     = 1'b1;
        w_next_state = ST_LU_STALL;
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_next_state;
  end

  // IF/ID register: load, flush to NOP, or hold depending on the winning event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr  <= NOP_INSTR;
      r_pcplus <= RESET_PCPLUS;
      r_valid  <= 1'b0;
    end else begin
      case (w_event)
        EV_NORMAL: begin
          r_instr  <= bus.instruction_in;
          r_pcplus <= bus.pcplus_in;
          r_valid  <= 1'b1;
        end
        EV_BRANCH, EV_JUMP: begin
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Saturating stall and flush counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_event == EV_LOAD_USE) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (((w_event == EV_BRANCH) || (w_event == EV_JUMP)) && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.instruction_out = r_instr;
  assign bus.pcplus_out      = r_pcplus;
  assign bus.valid_out       = r_valid;
  assign bus.pc_write        = w_pc_write;
  assign bus.idex_bubble     = w_bubble;
  assign bus.stall_cnt       = r_stall_cnt;
  assign bus.flush_cnt       = r_flush_cnt;
endmodule

// File: tb/tb_ifid_hazard_stage.sv
// Self-checking bench for ifid_hazard_stage: directed scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_ifid_hazard_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0040;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          CNT_W    = 16;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] INSTR_A  = 32'h012A_4020;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model state: what IF/ID holds, event counts, and whether the
  // previous cycle was a freeze or a stall (both mask load-use this cycle).
  logic [31:0] m_instr;
  logic [31:0] m_pcplus;
  logic        m_valid;
  logic        m_prev_busy;
  logic        m_prev_stall;
  int          m_stall;
  int          m_flush;
  logic        obs_pcw;
  logic        obs_bub;

  ifid_hazard_stage_if #(.CNT_W(CNT_W)) bus ();

  ifid_hazard_stage #(
    .RESET_PCPLUS (RESET_PC),
    .NOP_INSTR    (NOP),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_instr      = NOP;
    m_pcplus     = RESET_PC;
    m_valid      = 1'b0;
    m_prev_busy  = 1'b0;
    m_prev_stall = 1'b0;
    m_stall      = 0;
    m_flush      = 0;
  endtask

  task automatic idle_inputs();
    bus.instruction_in = 32'h0;
    bus.pcplus_in      = 32'h0;
    bus.idex_memrd     = 1'b0;
    bus.idex_rt        = 5'd0;
    bus.jump           = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.mem_busy       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle with the currently driven inputs. Combinational outputs are
  // sampled at the falling edge, registered outputs 1 time unit after the rise.
  task automatic step(input bit chk);
    logic dep, lu, e_pcw, e_bub;
    @(negedge clk);
    dep = bus.idex_memrd && (bus.idex_rt != 5'd0) && m_valid &&
          ((bus.idex_rt == m_instr[25:21]) || (bus.idex_rt == m_instr[20:16]));
    lu  = dep && !m_prev_busy && !m_prev_stall;
    e_pcw = !bus.mem_busy && (bus.branch_taken || !lu);
    e_bub = !bus.mem_busy && (bus.branch_taken || lu);
    obs_pcw = bus.pc_write;
    obs_bub = bus.idex_bubble;
    if (chk) begin
      check("pc_write", {31'b0, obs_pcw}, {31'b0, e_pcw});
      check("idex_bubble", {31'b0, obs_bub}, {31'b0, e_bub});
    end
    @(posedge clk);
    if (bus.mem_busy) begin
      m_prev_busy  = 1'b1;
      m_prev_stall = 1'b0;
    end else begin
      m_prev_busy  = 1'b0;
      m_prev_stall = !bus.branch_taken && lu;
      if (bus.branch_taken || (!lu && bus.jump)) begin
        m_instr = NOP;
        m_valid = 1'b0;
        if (m_flush < CNT_MAX) m_flush++;
      end else if (lu) begin
        if (m_stall < CNT_MAX) m_stall++;
      end else begin
        m_instr  = bus.instruction_in;
        m_pcplus = bus.pcplus_in;
        m_valid  = 1'b1;
      end
    end
    #1;
    if (chk) begin
      check("instruction_out", bus.instruction_out, m_instr);
      check("pcplus_out", bus.pcplus_out, m_pcplus);
      check("valid_out", {31'b0, bus.valid_out}, {31'b0, m_valid});
      check("stall_cnt", {16'b0, bus.stall_cnt}, m_stall);
      check("flush_cnt", {16'b0, bus.flush_cnt}, m_flush);
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b1;
    #3;
    check("reset instruction_out", bus.instruction_out, NOP);
    check("reset pcplus_out", bus.pcplus_out, RESET_PC);
    check("reset valid_out", {31'b0, bus.valid_out}, 32'd0);
    check("reset stall_cnt", {16'b0, bus.stall_cnt}, 32'd0);
    check("reset flush_cnt", {16'b0, bus.flush_cnt}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1);
    check("post-reset pc_write", {31'b0, obs_pcw}, 32'd1);

    // Load-use on Rs=9: one stall cycle, then resumes even with idex unchanged.
    bus.instruction_in = INSTR_A;
    bus.pcplus_in      = 32'h0000_0104;
    step(1'b1);
    bus.instruction_in = 32'h0000_1111;
    bus.pcplus_in      = 32'h0000_0108;
    bus.idex_memrd     = 1'b1;
    bus.idex_rt        = 5'd9;
    step(1'b1);
    check("lu pc_write", {31'b0, obs_pcw}, 32'd0);
    check("lu bubble", {31'b0, obs_bub}, 32'd1);
    check("lu ifid held", bus.instruction_out, INSTR_A);
    check("lu stall_cnt", {16'b0, bus.stall_cnt}, 32'd1);
    step(1'b1);
    check("after lu pc_write", {31'b0, obs_pcw}, 32'd1);
    check("after lu bubble", {31'b0, obs_bub}, 32'd0);
    check("after lu loaded", bus.instruction_out, 32'h0000_1111);

    // Zero register never stalls.
    do_reset();
    idle_inputs();
    bus.instruction_in = 32'h0000_4020;
    step(1'b1);
    bus.idex_memrd = 1'b1;
    bus.idex_rt    = 5'd0;
    step(1'b1);
    check("zero-reg pc_write", {31'b0, obs_pcw}, 32'd1);

    // Branch together with load-use (and jump): flush wins, counted once.
    do_reset();
    idle_inputs();
    bus.instruction_in = INSTR_A;
    step(1'b1);
    bus.idex_memrd   = 1'b1;
    bus.idex_rt      = 5'd9;
    bus.branch_taken = 1'b1;
    bus.jump         = 1'b1;
    step(1'b1);
    check("br+lu valid_out", {31'b0, bus.valid_out}, 32'd0);
    check("br+lu flush_cnt", {16'b0, bus.flush_cnt}, 32'd1);
    check("br+lu stall_cnt", {16'b0, bus.stall_cnt}, 32'd0);

    // Freeze for 3 cycles with a pending branch, then release into the flush.
    do_reset();
    idle_inputs();
    bus.instruction_in = INSTR_A;
    bus.pcplus_in      = 32'h0000_0200;
    step(1'b1);
    bus.instruction_in = 32'h0000_2222;
    bus.mem_busy       = 1'b1;
    bus.branch_taken   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("freeze pc_write", {31'b0, obs_pcw}, 32'd0);
      check("freeze ifid held", bus.instruction_out, INSTR_A);
      check("freeze flush_cnt", {16'b0, bus.flush_cnt}, 32'd0);
    end
    bus.mem_busy = 1'b0;
    step(1'b1);
    check("release flush valid", {31'b0, bus.valid_out}, 32'd0);
    check("release flush_cnt", {16'b0, bus.flush_cnt}, 32'd1);

    // Asynchronous reset in the middle of a load-use stall.
    do_reset();
    idle_inputs();
    bus.instruction_in = INSTR_A;
    step(1'b1);
    bus.idex_memrd = 1'b1;
    bus.idex_rt    = 5'd9;
    step(1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("async rst instruction_out", bus.instruction_out, NOP);
    check("async rst pcplus_out", bus.pcplus_out, RESET_PC);
    check("async rst valid_out", {31'b0, bus.valid_out}, 32'd0);
    check("async rst stall_cnt", {16'b0, bus.stall_cnt}, 32'd0);
    check("async rst pc_write", {31'b0, bus.pc_write}, 32'd1);
    reset = 1'b0;
    model_reset();
    idle_inputs();
    step(1'b1);
    check("post async rst pc_write", {31'b0, obs_pcw}, 32'd1);

    // Randomized traffic, biased so idex_rt often hits the held instruction.
    for (int i = 0; i < 400; i++) begin
      bus.instruction_in = $urandom;
      bus.pcplus_in      = $urandom;
      bus.idex_memrd     = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       bus.idex_rt = m_instr[25:21];
        1:       bus.idex_rt = m_instr[20:16];
        2:       bus.idex_rt = 5'd0;
        default: bus.idex_rt = 5'($urandom_range(0, 31));
      endcase
      bus.jump         = ($urandom_range(0, 5) == 0);
      bus.branch_taken = ($urandom_range(0, 7) == 0);
      bus.mem_busy     = ($urandom_range(0, 6) == 0);
      step(1'b1);
    end

    // Flush counter saturation.
    do_reset();
    idle_inputs();
    bus.jump = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 5; i++) step(1'b0);
    check("flush_cnt saturated", {16'b0, bus.flush_cnt}, 32'h0000_FFFF);
    check("flush_cnt model", {16'b0, bus.flush_cnt}, m_flush);
    step(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
